// File: rtl/usb_tx_crc16_append.sv
// Serial USB CRC16 (x^16+x^15+x^2+1, preset 0xFFFF): absorbs TX payload bits, then emits the complemented CRC MSB-first.
// Optional sticky protocol-error flag is built when USB_TX_CRC_ERR_EN is defined; otherwise proto_err is tied low.
module usb_tx_crc16_append (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       shift_en,
    input  logic       start_crc,
    input  logic       data_bit,
    input  logic       data_end,
    output logic       bit_out,
    output logic       crc_active,
    output logic       crc_done,
    output logic       busy,
    output logic       proto_err,
    output logic [1:0] state_dbg
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DATA = 2'd1,
        ST_CRC  = 2'd2
    } state_t;

    localparam logic [15:0] POLY   = 16'h8005;
    localparam logic [15:0] PRESET = 16'hFFFF;

    state_t      state_q, state_d;
    logic [15:0] crc_q, crc_d;
    logic [3:0]  bit_cnt_q, bit_cnt_d;
    logic        done_q, done_d;
    logic        fb;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q   <= ST_IDLE;
            crc_q     <= PRESET;
            bit_cnt_q <= 4'd0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            crc_q     <= crc_d;
            bit_cnt_q <= bit_cnt_d;
            done_q    <= done_d;
        end
    end

    // start_crc overrides everything, including a coincident shift_en or data_end.
    always_comb begin
        state_d   = state_q;
        crc_d     = crc_q;
        bit_cnt_d = bit_cnt_q;
        done_d    = 1'b0;
        fb        = crc_q[15] ^ data_bit;
        if (start_crc) begin
            state_d   = ST_DATA;
            crc_d     = PRESET;
            bit_cnt_d = 4'd0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                end
                ST_DATA: begin
                    if (data_end) begin
                        state_d   = ST_CRC;
                        bit_cnt_d = 4'd0;
                    end else if (shift_en) begin
                        crc_d = {crc_q[14:0], 1'b0} ^ (fb ? POLY : 16'h0000);
                    end
                end
                ST_CRC: begin
                    if (shift_en) begin
                        crc_d     = {crc_q[14:0], 1'b0};
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        if (bit_cnt_q == 4'd15) begin
                            state_d = ST_IDLE;
                            done_d  = 1'b1;
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    assign crc_active = (state_q == ST_CRC);
    assign busy       = (state_q != ST_IDLE);
    assign bit_out    = crc_active & ~crc_q[15];
    assign crc_done   = done_q;
    assign state_dbg  = state_q;

`ifdef USB_TX_CRC_ERR_EN
    logic err_q, err_d;

    // A start in IDLE clears the flag even if a violation is flagged in the same cycle.
    always_comb begin
        err_d = err_q;
        if (start_crc && (state_q == ST_IDLE)) begin
            err_d = 1'b0;
        end else if ((start_crc && (state_q == ST_CRC)) ||
                     (data_end && (state_q == ST_IDLE))) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign proto_err = err_q;
`else
    assign proto_err = 1'b0;
`endif

endmodule

// File: tb/tb_usb_tx_crc16_append.sv
// Bench for usb_tx_crc16_append: table vectors, random packets and corner sequences checked
// against a polynomial long-division CRC model.
module tb_usb_tx_crc16_append;

    logic       clk = 1'b0;
    logic       n_rst = 1'b0;
    logic       shift_en = 1'b0;
    logic       start_crc = 1'b0;
    logic       data_bit = 1'b0;
    logic       data_end = 1'b0;
    logic       bit_out;
    logic       crc_active;
    logic       crc_done;
    logic       busy;
    logic       proto_err;
    logic [1:0] state_dbg;

    int n_checks = 0;
    int n_fail = 0;

    logic [0:0] exp_q[$];
    logic [0:0] emit_q[$];
    logic       bit_q[$];
    logic [7:0] pay_q[$];

`ifdef USB_TX_CRC_ERR_EN
    localparam logic EXP_ERR = 1'b1;
`else
    localparam logic EXP_ERR = 1'b0;
`endif

    typedef struct {
        int          nbytes;
        logic [31:0] data;
        int          mode;
        logic [15:0] exp_emit;
    } vec_t;

    vec_t vecs[6];

    usb_tx_crc16_append dut (
        .clk        (clk),
        .n_rst      (n_rst),
        .shift_en   (shift_en),
        .start_crc  (start_crc),
        .data_bit   (data_bit),
        .data_end   (data_end),
        .bit_out    (bit_out),
        .crc_active (crc_active),
        .crc_done   (crc_done),
        .busy       (busy),
        .proto_err  (proto_err),
        .state_dbg  (state_dbg)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk1(input string name, input logic got, input logic exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", name, got, exp);
        end
    endtask

    task automatic chk16(input string name, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // CRC register value = remainder of (message * x^16, first 16 dividend bits inverted) / G.
    function automatic logic [15:0] model_crc();
        logic        d[$];
        logic [16:0] g;
        logic [15:0] r;
        g = 17'h18005;
        d = bit_q;
        for (int i = 0; i < 16; i++) d.push_back(1'b0);
        for (int i = 0; i < 16; i++) d[i] = ~d[i];
        for (int i = 0; i + 16 < d.size(); i++) begin
            if (d[i]) begin
                for (int j = 0; j <= 16; j++) d[i+j] = d[i+j] ^ g[16-j];
            end
        end
        for (int k = 0; k < 16; k++) r[15-k] = d[d.size()-16+k];
        return r;
    endfunction

    task automatic load_bits();
        bit_q = {};
        foreach (pay_q[b]) begin
            for (int k = 0; k < 8; k++) bit_q.push_back(pay_q[b][k]);
        end
    endtask

    function automatic int gap_at(input int mode, input int idx);
        if (mode != 0) return mode;
        case (idx % 3)
            0: return 1;
            1: return 3;
            default: return 7;
        endcase
    endfunction

    task automatic collect_crc(input int mode, input logic [15:0] exp_emit, input string name);
        logic cur;
        int   g;
        exp_q = {};
        for (int i = 0; i < 16; i++) exp_q.push_back(exp_emit[15-i]);
        emit_q = {};
        chk1({name, "_active"}, crc_active, 1'b1);
        for (int i = 0; i < 16; i++) begin
            cur = bit_out;
            chk1({name, "_bit"}, cur, exp_q.pop_front());
            emit_q.push_back(cur);
            g = gap_at(mode, i);
            repeat (g - 1) begin
                tick();
                chk1({name, "_hold"}, bit_out, cur);
            end
            shift_en = 1'b1;
            tick();
            shift_en = 1'b0;
        end
        chk1({name, "_done"}, crc_done, 1'b1);
        chk1({name, "_active_off"}, crc_active, 1'b0);
        chk1({name, "_busy_off"}, busy, 1'b0);
        tick();
        chk1({name, "_done_pulse"}, crc_done, 1'b0);
    endtask

    task automatic pkt_body(input int mode, input logic [15:0] exp_emit,
                            input logic end_with_shift, input string name);
        int idx;
        int g;
        idx = 0;
        foreach (pay_q[b]) begin
            for (int k = 0; k < 8; k++) begin
                data_bit = pay_q[b][k];
                shift_en = 1'b1;
                tick();
                shift_en = 1'b0;
                data_bit = 1'b0;
                g = gap_at(mode, idx);
                idx++;
                repeat (g - 1) tick();
            end
        end
        data_end = 1'b1;
        if (end_with_shift) begin
            shift_en = 1'b1;
            data_bit = 1'b1;
        end
        tick();
        data_end = 1'b0;
        shift_en = 1'b0;
        data_bit = 1'b0;
        collect_crc(mode, exp_emit, name);
        load_bits();
        foreach (emit_q[e]) bit_q.push_back(emit_q[e][0]);
        chk16({name, "_residual"}, model_crc(), 16'h800D);
    endtask

    task automatic run_packet(input int mode, input logic [15:0] exp_emit, input string name);
        start_crc = 1'b1;
        tick();
        start_crc = 1'b0;
        chk1({name, "_busy"}, busy, 1'b1);
        chk1({name, "_not_active"}, crc_active, 1'b0);
        pkt_body(mode, exp_emit, 1'b0, name);
    endtask

    task automatic load_payload(input int nbytes, input logic [31:0] data);
        pay_q = {};
        for (int i = 0; i < nbytes; i++) pay_q.push_back(data[8*i +: 8]);
    endtask

    initial begin
        logic [15:0] e;

        // Clock/reset
        repeat (3) tick();
        chk1("rst_bit_out", bit_out, 1'b0);
        chk1("rst_active", crc_active, 1'b0);
        chk1("rst_done", crc_done, 1'b0);
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_proto_err", proto_err, 1'b0);
        chk16("rst_state", {14'd0, state_dbg}, 16'd0);
        n_rst = 1'b1;
        tick();

        // Table of vectors; expectations from the model except the ZLP constant.
        vecs[0] = '{nbytes: 0, data: 32'h0,        mode: 1, exp_emit: 16'h0000};
        vecs[1] = '{nbytes: 4, data: 32'h03020100, mode: 1, exp_emit: 16'h0};
        vecs[2] = '{nbytes: 4, data: 32'h03020100, mode: 3, exp_emit: 16'h0};
        vecs[3] = '{nbytes: 4, data: 32'h03020100, mode: 0, exp_emit: 16'h0};
        vecs[4] = '{nbytes: 1, data: 32'hFF,       mode: 2, exp_emit: 16'h0};
        vecs[5] = '{nbytes: 2, data: 32'h3412,     mode: 1, exp_emit: 16'h0};
        for (int v = 1; v < 6; v++) begin
            load_payload(vecs[v].nbytes, vecs[v].data);
            load_bits();
            vecs[v].exp_emit = ~model_crc();
        end
        for (int v = 0; v < 6; v++) begin
            load_payload(vecs[v].nbytes, vecs[v].data);
            run_packet(vecs[v].mode, vecs[v].exp_emit, $sformatf("vec%0d", v));
            chk1($sformatf("vec%0d_proto_err", v), proto_err, 1'b0);
        end

        // Random packets
        for (int r = 0; r < 8; r++) begin
            pay_q = {};
            for (int i = 0; i < int'($urandom_range(0, 5)); i++)
                pay_q.push_back(8'($urandom_range(0, 255)));
            load_bits();
            e = ~model_crc();
            run_packet(int'($urandom_range(1, 3)), e, $sformatf("rnd%0d", r));
        end

        // Abort mid-append after 5 CRC bits
        start_crc = 1'b1;
        tick();
        start_crc = 1'b0;
        data_end = 1'b1;
        tick();
        data_end = 1'b0;
        repeat (5) begin
            shift_en = 1'b1;
            tick();
            shift_en = 1'b0;
        end
        start_crc = 1'b1;
        tick();
        start_crc = 1'b0;
        chk1("abort_busy", busy, 1'b1);
        chk1("abort_active", crc_active, 1'b0);
        chk1("abort_proto_err", proto_err, EXP_ERR);
        for (int i = 0; i < 20; i++) begin
            tick();
            chk1("abort_no_done", crc_done, 1'b0);
        end
        load_payload(4, 32'h03020100);
        load_bits();
        e = ~model_crc();
        pkt_body(1, e, 1'b0, "after_abort");
        chk1("abort_err_sticky", proto_err, EXP_ERR);
        start_crc = 1'b1;
        tick();
        start_crc = 1'b0;
        chk1("abort_err_clear", proto_err, 1'b0);
        pay_q = {};
        pkt_body(1, 16'h0000, 1'b0, "clear_zlp");

        // data_end coincident with shift_en: the bit must not be absorbed
        start_crc = 1'b1;
        tick();
        start_crc = 1'b0;
        load_payload(1, 32'hA5);
        load_bits();
        e = ~model_crc();
        pkt_body(2, e, 1'b1, "end_shift");

        // start_crc coincident with shift_en in DATA restarts cleanly
        start_crc = 1'b1;
        tick();
        start_crc = 1'b0;
        repeat (5) begin
            data_bit = 1'b1;
            shift_en = 1'b1;
            tick();
        end
        start_crc = 1'b1;
        tick();
        start_crc = 1'b0;
        shift_en = 1'b0;
        data_bit = 1'b0;
        load_payload(2, 32'h3412);
        load_bits();
        e = ~model_crc();
        pkt_body(1, e, 1'b0, "start_shift");
        chk1("start_shift_proto_err", proto_err, 1'b0);

        // data_end in IDLE, then start+data_end in IDLE (clear wins)
        data_end = 1'b1;
        tick();
        data_end = 1'b0;
        chk1("idle_end_err", proto_err, EXP_ERR);
        chk1("idle_end_busy", busy, 1'b0);
        tick();
        chk1("idle_end_err_sticky", proto_err, EXP_ERR);
        start_crc = 1'b1;
        data_end = 1'b1;
        tick();
        start_crc = 1'b0;
        data_end = 1'b0;
        chk1("clear_prio_err", proto_err, 1'b0);
        chk1("clear_prio_active", crc_active, 1'b0);
        pay_q = {};
        pkt_body(3, 16'h0000, 1'b0, "clear_prio_zlp");

        // Reset during CRC emission
        start_crc = 1'b1;
        tick();
        start_crc = 1'b0;
        data_end = 1'b1;
        tick();
        data_end = 1'b0;
        repeat (3) begin
            shift_en = 1'b1;
            tick();
            shift_en = 1'b0;
        end
        n_rst = 1'b0;
        #1;
        chk1("midrst_bit_out", bit_out, 1'b0);
        chk1("midrst_active", crc_active, 1'b0);
        chk1("midrst_busy", busy, 1'b0);
        chk1("midrst_done", crc_done, 1'b0);
        chk1("midrst_proto_err", proto_err, 1'b0);
        tick();
        n_rst = 1'b1;
        for (int i = 0; i < 16; i++) begin
            shift_en = 1'b1;
            tick();
            shift_en = 1'b0;
            chk1("midrst_no_done", crc_done, 1'b0);
        end
        load_payload(4, 32'h03020100);
        load_bits();
        e = ~model_crc();
        run_packet(1, e, "post_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/usb_tx_crc16_append.md
# usb_tx_crc16_append

Serial CRC16 generator for the USB transmit path of the bulk endpoint. It accumulates the DATA0/DATA1 payload bit-by-bit as the TX shifter sends it, then emits the 16 complemented CRC bits serially so the TX encoder can append them before EOP. It sits between the TX payload shifter and the NRZI/bit-stuff encoder and is paced by the same bit-time strobe.

## Interface
- No parameters. Polynomial x^16+x^15+x^2+1 (0x8005) and preset 0xFFFF are fixed.
- clk  input  1  system clock
- n_rst  input  1  reset, asynchronous, active-low
- shift_en  input  1  one-cycle strobe per USB bit time; all bit consumption and emission advance only on it
- start_crc  input  1  one-cycle pulse: begin new packet, preset CRC
- data_bit  input  1  payload bit, LSB-first per byte, sampled when shift_en=1 in DATA
- data_end  input  1  one-cycle pulse after the last payload bit; consumes no bit
- bit_out  output  1  current CRC bit to transmit; 0 outside CRC state
- crc_active  output  1  high while in CRC state; encoder selects bit_out
- crc_done  output  1  one-cycle pulse after the final CRC bit is shifted
- busy  output  1  high in DATA or CRC
- proto_err  output  1  sticky protocol-violation flag (see Configuration)

## Operation
- States: IDLE, DATA, CRC. 16-bit register crc, 4-bit counter bit_cnt.
- IDLE: start_crc -> DATA, crc <= 0xFFFF, bit_cnt <= 0. data_end and shift_en ignored.
- DATA, shift_en=1 and data_end=0: fb = crc[15]^data_bit; crc <= {crc[14:0],1'b0} ^ (fb ? 0x8005 : 0).
- DATA, data_end=1: -> CRC, crc unchanged, bit_cnt <= 0. A shift_en coincident with data_end is ignored (no bit consumed).
- CRC: bit_out = ~crc[15]. On shift_en: crc <= {crc[14:0],1'b0}, bit_cnt <= bit_cnt+1; when bit_cnt==15 -> IDLE and crc_done asserts next cycle.
- start_crc in DATA or CRC: abort, restart at DATA with crc=0xFFFF, bit_cnt=0; no crc_done for aborted packet.
- Zero-length packet: start_crc then data_end -> 16 emitted bits all 0.
- crc_active = (state==CRC); busy = (state!=IDLE).

## Timing
- Reset: state IDLE, crc=0xFFFF, bit_cnt=0; bit_out=0, crc_active=0, crc_done=0, busy=0, proto_err=0.
- start_crc at edge N -> busy=1 from cycle N+1.
- data_end at edge N -> crc_active=1 and bit_out valid (CRC bit 15, complemented) from cycle N+1; first emitted bit held until next shift_en.
- Emission: CRC bits x^15 coefficient first, each held exactly one bit time (shift_en to shift_en).
- 16th shift_en in CRC at edge M -> state IDLE, crc_active=0, crc_done=1 during cycle M+1 only.
- start_crc and shift_en same cycle: start_crc wins; shift_en ignored.
- Reset asserted mid-packet: immediate return to reset values, no crc_done.

## Configuration
- Macro USB_TX_CRC_ERR_EN.
- Defined: proto_err sets on start_crc while in CRC (abort mid-append) or data_end while in IDLE; cleared only by start_crc received in IDLE (clear has priority over set in that cycle) or reset.
- Undefined: proto_err port exists, tied 0; no extra logic.

## Test plan
- Reset mid-CRC emission -> all outputs at reset values, then start_crc works normally.
- ZLP: start_crc, data_end, 16 shift_en -> bit_out=0 for all 16 bits, crc_done one cycle after 16th strobe.
- Payload 0x00 0x01 0x02 0x03 LSB-first, data_end, 16 strobes -> payload+emitted bits through reference CRC16 checker give residual 0x800D; emitted bits match model's complemented CRC MSB-first.
- Irregular shift_en spacing (1, 3, 7 cycles) with same payload -> identical 16-bit emission; bit_out stable between strobes.
- start_crc after 5 CRC bits -> restart, no crc_done; with USB_TX_CRC_ERR_EN proto_err=1 until next start_crc in IDLE, without it proto_err=0.
- data_end coincident with shift_en carrying data_bit=1 -> bit not absorbed; CRC equals that of payload excluding it.
